// File: rtl/oem_bisu_feeder_if.sv
// Feeder bundle: upstream key handshake plus the sorter-facing lane data and control strobes.
interface oem_bisu_feeder_if #(
    parameter int unsigned W = 6
);
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         inv;
    logic [W-1:0] di1;
    logic [W-1:0] di2;
    logic [W-1:0] di3;
    logic [W-1:0] di4;
    logic         en_out;
    logic         inv_out;
    logic         vin;
    logic [7:0]   rst_seq;
    logic         busy;

    modport master (
        output s_valid, s_data, inv,
        input  s_ready, di1, di2, di3, di4, en_out, inv_out, vin, rst_seq, busy
    );

    modport slave (
        input  s_valid, s_data, inv,
        output s_ready, di1, di2, di3, di4, en_out, inv_out, vin, rst_seq, busy
    );
endinterface

// File: rtl/oem_bisu_feeder.sv
// Packs 16 serial keys into four 4-lane beats and plays each frame with the sorter control
// sequence. Define OEM_FEEDER_PINGPONG_EN for two frame buffers (fill overlaps playback).
module oem_bisu_feeder #(
    parameter int unsigned W = 6,
    parameter int unsigned P = 4
) (
    input logic              clk,
    input logic              rst_n,
    oem_bisu_feeder_if.slave bus
);
    localparam int unsigned Keys = 4 * P;
`ifdef OEM_FEEDER_PINGPONG_EN
    localparam int unsigned NumBuf = 2;
`else
    localparam int unsigned NumBuf = 1;
`endif
    localparam int unsigned AddrW = $clog2(NumBuf * Keys);

    typedef enum logic [1:0] {StIdle, StFill, StPlay} state_e;

    state_e            state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NumBuf-1:0] full_q, full_d;
    logic [NumBuf-1:0] finv_q, finv_d;
    logic              wr_sel_q, rd_sel_q, rd_sel_d;
    logic              accept, last_key, pending;
    logic [W-1:0]      mem_q [NumBuf*Keys];
    logic [AddrW-1:0]  wr_addr;
    logic [AddrW-1:0]  rd_addr [4];
    logic [3:0]        key_idx [4];

    logic [W-1:0]      di_q [4];
    logic [W-1:0]      di_d [4];
    logic [7:0]        rst_seq_q, rst_seq_d;
    logic              vin_q, vin_d, en_q, en_d, inv_out_q, inv_out_d, busy_q, busy_d;

    assign bus.s_ready = !full_q[wr_sel_q];
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_key    = accept && (cnt_q == 4'd15);

`ifdef OEM_FEEDER_PINGPONG_EN
    // The other buffer holds a complete frame, or completes one this cycle.
    assign pending = full_q[~rd_sel_q] || (last_key && (wr_sel_q != rd_sel_q));
    assign wr_addr = {wr_sel_q, cnt_q};

    always_comb begin
        rd_sel_d = rd_sel_q;
        if (state_q == StFill && last_key) begin
            rd_sel_d = wr_sel_q;
        end else if (state_q == StPlay && step_q == 4'd8 && pending) begin
            rd_sel_d = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_q ^ last_key;
            rd_sel_q <= rd_sel_d;
        end
    end
`else
    assign pending  = 1'b0;
    assign wr_addr  = cnt_q;
    assign wr_sel_q = 1'b0;
    assign rd_sel_q = 1'b0;
    assign rd_sel_d = 1'b0;
`endif

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            key_idx[l] = 4'((32'(step_d) - 32'd1) * P + 32'(l));
`ifdef OEM_FEEDER_PINGPONG_EN
            rd_addr[l] = {rd_sel_d, key_idx[l]};
`else
            rd_addr[l] = key_idx[l];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = accept ? cnt_q + 4'd1 : cnt_q;
        full_d  = full_q;
        finv_d  = finv_q;
        if (accept && cnt_q == 4'd0) finv_d[wr_sel_q] = bus.inv;
        if (state_q == StPlay && step_q == 4'd8) full_d[rd_sel_q] = 1'b0;
        if (last_key) full_d[wr_sel_q] = 1'b1;
        unique case (state_q)
            StIdle: if (accept) state_d = StFill;
            StFill: begin
                if (last_key) begin
                    state_d = StPlay;
                    step_d  = 4'd0;
                end
            end
            StPlay: begin
                if (step_q != 4'd8) step_d = step_q + 4'd1;
                else if (pending) step_d = 4'd0;
                else if (cnt_d != 4'd0) state_d = StFill;
                else state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        rst_seq_d = '0;
        vin_d     = 1'b0;
        en_d      = 1'b0;
        busy_d    = 1'b0;
        inv_out_d = inv_out_q;
        for (int l = 0; l < 4; l++) di_d[l] = '0;
        if (state_d == StPlay) begin
            en_d      = 1'b1;
            busy_d    = 1'b1;
            inv_out_d = finv_q[rd_sel_d];
            vin_d     = (step_d == 4'd8);
            if (step_d <= 4'd7) rst_seq_d = 8'd1 << step_d;
            for (int l = 0; l < 4; l++) begin
                if (step_d >= 4'd1 && step_d <= 4'd4) di_d[l] = mem_q[rd_addr[l]];
                else if (step_d >= 4'd7) di_d[l] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_addr] <= bus.s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            step_q    <= 4'd0;
            cnt_q     <= 4'd0;
            full_q    <= '0;
            finv_q    <= '0;
            rst_seq_q <= '0;
            vin_q     <= 1'b0;
            en_q      <= 1'b0;
            inv_out_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int l = 0; l < 4; l++) di_q[l] <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            finv_q    <= finv_d;
            rst_seq_q <= rst_seq_d;
            vin_q     <= vin_d;
            en_q      <= en_d;
            inv_out_q <= inv_out_d;
            busy_q    <= busy_d;
            for (int l = 0; l < 4; l++) di_q[l] <= di_d[l];
        end
    end

    assign bus.di1     = di_q[0];
    assign bus.di2     = di_q[1];
    assign bus.di3     = di_q[2];
    assign bus.di4     = di_q[3];
    assign bus.rst_seq = rst_seq_q;
    assign bus.vin     = vin_q;
    assign bus.en_out  = en_q;
    assign bus.inv_out = inv_out_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_oem_bisu_feeder.sv
// Self-checking bench for oem_bisu_feeder: spec-derived step table plus a frame-queue reference.
module tb_oem_bisu_feeder;
    localparam int unsigned W = 6;
`ifdef OEM_FEEDER_PINGPONG_EN
    localparam int NumBuf = 2;
`else
    localparam int NumBuf = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    oem_bisu_feeder_if #(.W(W)) bus ();
    oem_bisu_feeder #(.W(W), .P(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0]   rs;
        logic         vin;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] d3;
        logic [W-1:0] d4;
    } step_t;
    step_t tbl [9];

    typedef struct packed {
        logic [16*W-1:0] keys;
        logic            inv;
    } frame_t;

    frame_t       pend_q[$];
    logic [W-1:0] part_q[$];
    logic         part_inv;
    bit           playing;
    int           pstep;
    frame_t       pf;
    logic         m_inv;
    bit           watch_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return (pend_q.size() + (playing ? 1 : 0)) < NumBuf;
    endfunction

    task automatic m_reset();
        pend_q.delete();
        part_q.delete();
        playing  = 0;
        pstep    = 0;
        m_inv    = 1'b0;
        part_inv = 1'b0;
    endtask

    task automatic m_update(input bit acc, input logic [W-1:0] data, input logic inv);
        frame_t f;
        if (playing && pstep == 8) playing = 0;
        if (acc) begin
            if (part_q.size() == 0) part_inv = inv;
            part_q.push_back(data);
            if (part_q.size() == 16) begin
                for (int i = 0; i < 16; i++) f.keys[i*W +: W] = part_q[i];
                f.inv = part_inv;
                pend_q.push_back(f);
                part_q.delete();
            end
        end
        if (playing) begin
            pstep++;
        end else if (pend_q.size() != 0) begin
            pf      = pend_q.pop_front();
            playing = 1;
            pstep   = 0;
            m_inv   = pf.inv;
        end
    endtask

    function automatic logic [63:0] m_expect();
        logic [W-1:0] d [4];
        logic [7:0]   rs;
        logic         v, e;
        rs = '0;
        v  = 1'b0;
        e  = 1'b0;
        for (int l = 0; l < 4; l++) d[l] = '0;
        if (playing) begin
            e = 1'b1;
            v = (pstep == 8);
            if (pstep <= 7) rs = 8'(1 << pstep);
            for (int l = 0; l < 4; l++) begin
                if (pstep >= 1 && pstep <= 4) d[l] = pf.keys[((pstep - 1) * 4 + l) * W +: W];
                else if (pstep >= 7) d[l] = '1;
            end
        end
        return 64'({d[0], d[1], d[2], d[3], rs, v, e, m_inv, e, m_ready()});
    endfunction

    function automatic logic [63:0] act_vec();
        return 64'({bus.di1, bus.di2, bus.di3, bus.di4, bus.rst_seq, bus.vin, bus.en_out,
                    bus.inv_out, bus.busy, bus.s_ready});
    endfunction

    task automatic cyc();
        bit acc;
        acc = bus.s_valid && m_ready();
        if (watch_ready) chk("ready_hi", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_update(acc, bus.s_data, bus.inv);
        #1;
        chk("cycle", act_vec(), m_expect());
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_data  = '1;
        repeat (n) cyc();
    endtask

    task automatic send_keys(input logic [W-1:0] k [16], input int n, input logic inv0,
                             input int gap_pct);
        int idx = 0;
        int budget = 0;
        bit v, acc;
        while (idx < n && budget < 200) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            bus.s_valid = v;
            bus.s_data  = v ? k[idx] : '1;
            bus.inv     = (idx == 0) ? inv0 : ~inv0;
            acc = v && m_ready();
            cyc();
            if (acc) idx++;
            budget++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '1;
        if (idx < n) chk("send_timeout", 64'(idx), 64'(n));
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_step%0d", tag, i),
                64'({bus.di1, bus.di2, bus.di3, bus.di4, bus.rst_seq, bus.vin, bus.en_out,
                     bus.busy}),
                64'({tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].d4, tbl[i].rs, tbl[i].vin,
                     2'b11}));
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] nom [16];
        logic [W-1:0] rev [16];
        logic [W-1:0] rnd [16];
        logic [W-1:0] rnd2 [16];
        logic         rinv;

        nom = '{6'd19, 6'd45, 6'd12, 6'd50, 6'd38, 6'd29, 6'd10, 6'd55,
                6'd25, 6'd40, 6'd7, 6'd52, 6'd13, 6'd22, 6'd33, 6'd59};
        for (int i = 0; i < 16; i++) rev[i] = nom[15 - i];
        tbl[0] = {8'h01, 1'b0, 6'd0,  6'd0,  6'd0,  6'd0};
        tbl[1] = {8'h02, 1'b0, 6'd19, 6'd45, 6'd12, 6'd50};
        tbl[2] = {8'h04, 1'b0, 6'd38, 6'd29, 6'd10, 6'd55};
        tbl[3] = {8'h08, 1'b0, 6'd25, 6'd40, 6'd7,  6'd52};
        tbl[4] = {8'h10, 1'b0, 6'd13, 6'd22, 6'd33, 6'd59};
        tbl[5] = {8'h20, 1'b0, 6'd0,  6'd0,  6'd0,  6'd0};
        tbl[6] = {8'h40, 1'b0, 6'd0,  6'd0,  6'd0,  6'd0};
        tbl[7] = {8'h80, 1'b0, 6'd63, 6'd63, 6'd63, 6'd63};
        tbl[8] = {8'h00, 1'b1, 6'd63, 6'd63, 6'd63, 6'd63};

        bus.s_valid = 1'b0;
        bus.s_data  = '1;
        bus.inv     = 1'b0;
        watch_ready = 0;
        m_reset();

        #1 rst_n = 1'b0;
        #11;
        chk("reset", act_vec(), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal frame, then the same frame with random valid gaps.
        send_keys(nom, 16, 1'b0, 0);
        check_table("nom");
        idle(2);
        send_keys(nom, 16, 1'b0, 35);
        check_table("gap");
        idle(2);

        // Two frames back to back, second reversed with inv=1.
        send_keys(nom, 16, 1'b0, 0);
`ifdef OEM_FEEDER_PINGPONG_EN
        watch_ready = 1;
`endif
        send_keys(rev, 16, 1'b1, 0);
        watch_ready = 0;
        chk("f2_step0", 64'({bus.rst_seq, bus.inv_out}), 64'({8'h01, 1'b1}));
        idle(12);

`ifndef OEM_FEEDER_PINGPONG_EN
        // Single buffer: keys offered during playback must be refused.
        for (int i = 0; i < 16; i++) rnd[i] = W'($urandom);
        send_keys(rnd, 16, 1'b1, 0);
        for (int i = 0; i < 9; i++) begin
            chk("sr_low", 64'(bus.s_ready), 64'd0);
            bus.s_valid = 1'b1;
            bus.s_data  = W'($urandom);
            cyc();
        end
        bus.s_valid = 1'b0;
        chk("sr_high", 64'(bus.s_ready), 64'd1);
        for (int i = 0; i < 16; i++) rnd[i] = W'($urandom);
        send_keys(rnd, 16, 1'b0, 10);
        idle(12);
`endif

        // Asynchronous reset at step 3 of playback.
        for (int i = 0; i < 16; i++) rnd[i] = W'($urandom);
        send_keys(rnd, 16, 1'b1, 0);
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_async", act_vec(), 64'd1);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) rnd[i] = W'($urandom);
        send_keys(rnd, 16, 1'b1, 20);
        idle(12);

        // Reset after seven keys of a partial frame.
        for (int i = 0; i < 16; i++) rnd[i] = W'($urandom);
        send_keys(rnd, 7, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        m_reset();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) rnd2[i] = W'($urandom);
        send_keys(rnd2, 16, 1'b0, 0);
        cyc();
        chk("fill_beat0", 64'({bus.di1, bus.di2, bus.di3, bus.di4}),
            64'({rnd2[0], rnd2[1], rnd2[2], rnd2[3]}));
        idle(12);

        // Randomized frames with random gaps and directions.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 16; i++) rnd[i] = W'($urandom);
            rinv = 1'($urandom);
            send_keys(rnd, 16, rinv, int'($urandom_range(0, 50)));
        end
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
